div_mem_seq: RTL and testbench
==============================

DIV_MEM_SEQ -- requirements
Module: div_mem_seq

Interface
REQ-001 SHALL have parameter NUM_DIV, default 8, number of divider channels whose done flags are joined.
REQ-002 SHALL have parameter ADDR_W, default 16, scratch-memory address width.
REQ-003 SHALL have parameter RD_BASE, default 64, first read line address.
REQ-004 SHALL have parameter WR_BASE, default 128, first write line address.
REQ-005 SHALL have parameter NUM_LINES, default 64, lines per run; even, 2..254.
REQ-006 SHALL have parameter RD_LAT, default 2, memory read latency in cycles, 1..15.
REQ-007 SHALL have parameter WR_GAP, default 2, idle cycles after each write, 0..15.
REQ-008 SHALL have parameter TIMEOUT, default 1023, maximum cycles to wait for dividers, 1..65535.
REQ-009 clk  input  1  clock; all logic on rising edge.
REQ-010 reset  input  1  synchronous, active-high reset.
REQ-011 start  input  1  one-cycle run request.
REQ-012 div_done  input  NUM_DIV  per-divider done flags, level.
REQ-013 rd_addr1  output  ADDR_W  even-line read address.
REQ-014 rd_addr2  output  ADDR_W  odd-line read address.
REQ-015 rd_data_rdy  output  1  read data valid pulse.
REQ-016 div_en  output  1  divider launch pulse.
REQ-017 wr_en  output  1  write strobe.
REQ-018 wr_addr  output  ADDR_W  write address, valid with wr_en.
REQ-019 busy  output  1  run in progress.
REQ-020 rd_done, wr_done  output  1 each  end-of-run pulses.
REQ-021 err  output  1  sticky divider-timeout flag.

Function
REQ-022 SHALL use one registered FSM with states IDLE, RD_ISSUE, RD_WAIT, RD_RDY, DIV_WAIT, WR_A, GAP_A, WR_B, GAP_B, DONE; all outputs registered.
REQ-023 IDLE: start=1 -> RD_ISSUE, clear err, pair index k=0. Otherwise remain in IDLE.
REQ-024 start while not IDLE SHALL be ignored; no queuing.
REQ-025 RD_ISSUE: rd_addr1=RD_BASE+2k, rd_addr2=RD_BASE+2k+1 (mod 2^ADDR_W); addresses held until next RD_ISSUE; -> RD_WAIT.
REQ-026 RD_WAIT SHALL last exactly RD_LAT cycles, then -> RD_RDY.
REQ-027 RD_RDY: rd_data_rdy=1 and div_en=1 for exactly one cycle; -> DIV_WAIT.
REQ-028 DIV_WAIT SHALL ignore div_done in its first cycle (stale-done blanking), then leave on &div_done=1 -> WR_A.
REQ-029 DIV_WAIT SHALL count cycles; if the count reaches TIMEOUT without all-done -> DONE with err=1, no writes for that pair.
REQ-030 WR_A: wr_en=1 one cycle, wr_addr=WR_BASE+2k; -> GAP_A (WR_GAP cycles, wr_en=0; skipped if WR_GAP=0).
REQ-031 WR_B: wr_en=1 one cycle, wr_addr=WR_BASE+2k+1; -> GAP_B (WR_GAP cycles).
REQ-032 After GAP_B: k<NUM_LINES/2-1 -> k+1, RD_ISSUE; else -> DONE.
REQ-033 DONE: rd_done=1 and wr_done=1 for one cycle; -> IDLE. err SHALL hold until the next accepted start.
REQ-034 busy SHALL be 1 in every state except IDLE.
REQ-035 Pair counter width SHALL be ceil(log2(NUM_LINES/2))+1; wait counters sized for RD_LAT, WR_GAP and TIMEOUT.
REQ-036 Cycle timing: start sampled at edge T -> RD_ISSUE outputs visible after T+1; div_en visible after edge T+2+RD_LAT.
REQ-037 The design SHALL produce exactly NUM_LINES/2 div_en pulses and NUM_LINES wr_en pulses per run without timeout. Write addresses SHALL start at WR_BASE with no offset.

Reset
REQ-038 With reset=1 at a clock edge, the FSM SHALL go to IDLE. Counters SHALL clear. rd_addr1, rd_addr2, wr_addr SHALL be 0. rd_data_rdy, div_en, wr_en, busy, rd_done, wr_done, err SHALL be 0.
REQ-039 Reset mid-run SHALL abort with no further strobes. start in the same cycle as reset SHALL be ignored.

Verification
REQ-040 Defaults, start at edge 0, div_done all high 3 cycles after each div_en -> 32 div_en pulses. 64 wr_en pulses with wr_addr 128..191 in order. rd_addr1 64,66..126. One rd_done/wr_done pulse. busy then 0.
REQ-041 Latency, RD_LAT=2: start at edge 0 -> rd_addr1=64 after edge 1, div_en=1 after edge 4 only.
REQ-042 div_done held all-ones throughout -> each DIV_WAIT lasts 2 cycles (blanking), run completes normally.
REQ-043 div_done[3] stuck 0 on pair 0 -> no wr_en. After 1023 wait cycles: rd_done/wr_done pulse, err=1, busy=0. Next start -> err=0.
REQ-044 start pulsed during DIV_WAIT -> ignored, pair count unchanged. reset asserted during GAP_A of pair 5 -> all outputs 0 next cycle, no WR_B.
REQ-045 NUM_LINES=2, WR_GAP=0, NUM_DIV=1 -> one div_en, writes at WR_BASE and WR_BASE+1 in adjacent cycles, then DONE.

Source files
------------

// File: rtl/div_mem_seq.sv
// div_mem_seq: paced read / divide / write sequencer over a scratch memory.
// Walks NUM_LINES lines as even/odd pairs; every output is registered.
module div_mem_seq #(
  parameter int NUM_DIV   = 8,
  parameter int ADDR_W    = 16,
  parameter int RD_BASE   = 64,
  parameter int WR_BASE   = 128,
  parameter int NUM_LINES = 64,
  parameter int RD_LAT    = 2,
  parameter int WR_GAP    = 2,
  parameter int TIMEOUT   = 1023
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [NUM_DIV-1:0] div_done,
  output logic [ADDR_W-1:0]  rd_addr1,
  output logic [ADDR_W-1:0]  rd_addr2,
  output logic               rd_data_rdy,
  output logic               div_en,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic               busy,
  output logic               rd_done,
  output logic               wr_done,
  output logic               err
);

  localparam int PAIRS = NUM_LINES / 2;
  localparam int K_W   = $clog2(PAIRS) + 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int CNT_W = (TO_W > 4) ? TO_W : 4;

  localparam logic [ADDR_W-1:0] P_RD = ADDR_W'(RD_BASE);
  localparam logic [ADDR_W-1:0] P_WR = ADDR_W'(WR_BASE);
  localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);

  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST =
    CNT_W'((WR_GAP > 0) ? WR_GAP - 1 : 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [K_W-1:0]   K_LAST = K_W'(PAIRS - 1);

  typedef enum logic [3:0] {
    IDLE, RD_ISSUE, RD_WAIT, RD_RDY, DIV_WAIT,
    WR_A, GAP_A, WR_B, GAP_B, DONE
  } state_t;

  state_t            r_state;
  state_t            w_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt;
  logic [K_W-1:0]    r_k;
  logic [K_W-1:0]    w_k;
  logic              r_err;
  logic              w_err;
  logic [ADDR_W-1:0] w_off;
  logic [ADDR_W-1:0] w_rd1;
  logic [ADDR_W-1:0] w_rd2;
  logic [ADDR_W-1:0] w_wra;
  logic              w_rdy;
  logic              w_wen;
  logic              w_done;
  logic              w_busy;

  assign w_off = ADDR_W'(r_k) << 1;
  assign err   = r_err;

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_k     = r_k;
    w_err   = r_err;
    w_rd1   = rd_addr1;
    w_rd2   = rd_addr2;
    w_wra   = wr_addr;
    w_rdy   = 1'b0;
    w_wen   = 1'b0;
    w_done  = 1'b0;
    w_busy  = (r_state != IDLE);
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state = RD_ISSUE;
          w_k     = '0;
          w_err   = 1'b0;
        end
      end
      RD_ISSUE: begin
        w_rd1   = P_RD + w_off;
        w_rd2   = P_RD + w_off + A_ONE;
        w_cnt   = '0;
        w_state = RD_WAIT;
      end
      RD_WAIT: begin
        if (r_cnt == RD_LAST) w_state = RD_RDY;
        else w_cnt = r_cnt + CNT_W'(1);
      end
      RD_RDY: begin
        w_rdy   = 1'b1;
        w_cnt   = '0;
        w_state = DIV_WAIT;
      end
      DIV_WAIT: begin
        // first cycle may still see the previous pair's done flags
        if (r_cnt != '0 && &div_done) begin
          w_state = WR_A;
        end else if (r_cnt == TO_LAST) begin
          w_state = DONE;
          w_err   = 1'b1;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      WR_A: begin
        w_wen   = 1'b1;
        w_wra   = P_WR + w_off;
        w_cnt   = '0;
        w_state = (WR_GAP == 0) ? WR_B : GAP_A;
      end
      GAP_A: begin
        if (r_cnt == GAP_LAST) w_state = WR_B;
        else w_cnt = r_cnt + CNT_W'(1);
      end
      WR_B: begin
        w_wen = 1'b1;
        w_wra = P_WR + w_off + A_ONE;
        w_cnt = '0;
        if (WR_GAP != 0) begin
          w_state = GAP_B;
        end else if (r_k < K_LAST) begin
          w_k     = r_k + K_W'(1);
          w_state = RD_ISSUE;
        end else begin
          w_state = DONE;
        end
      end
      GAP_B: begin
        if (r_cnt != GAP_LAST) begin
          w_cnt = r_cnt + CNT_W'(1);
        end else if (r_k < K_LAST) begin
          w_k     = r_k + K_W'(1);
          w_state = RD_ISSUE;
        end else begin
          w_state = DONE;
        end
      end
      DONE: begin
        w_done  = 1'b1;
        w_state = IDLE;
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_k         <= '0;
      r_err       <= 1'b0;
      rd_addr1    <= '0;
      rd_addr2    <= '0;
      wr_addr     <= '0;
      rd_data_rdy <= 1'b0;
      div_en      <= 1'b0;
      wr_en       <= 1'b0;
      busy        <= 1'b0;
      rd_done     <= 1'b0;
      wr_done     <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_k         <= w_k;
      r_err       <= w_err;
      rd_addr1    <= w_rd1;
      rd_addr2    <= w_rd2;
      wr_addr     <= w_wra;
      rd_data_rdy <= w_rdy;
      div_en      <= w_rdy;
      wr_en       <= w_wen;
      busy        <= w_busy;
      rd_done     <= w_done;
      wr_done     <= w_done;
    end
  end

endmodule

// File: tb/tb_div_mem_seq.sv
// tb_div_mem_seq: directed bench with a timestamp-level run model.
// Second instance covers the two-line, no-gap, single-divider build.
module tb_div_mem_seq;

  localparam int RB = 64;
  localparam int WB = 128;
  localparam int NL = 64;
  localparam int RL = 2;
  localparam int WG = 2;
  localparam int TO = 1023;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        start2;
  logic [7:0]  dd = 8'hFF;
  logic [0:0]  dd2 = 1'b1;
  logic [15:0] rd_addr1, rd_addr2, wr_addr;
  logic        rd_data_rdy, div_en, wr_en;
  logic        busy, rd_done, wr_done, err;
  logic [15:0] rd_addr1_2, rd_addr2_2, wr_addr_2;
  logic        rd_data_rdy_2, div_en_2, wr_en_2;
  logic        busy_2, rd_done_2, wr_done_2, err_2;

  always #5 clk = ~clk;

  div_mem_seq u_dut (
    .clk(clk), .reset(reset), .start(start),
    .div_done(dd),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data_rdy(rd_data_rdy), .div_en(div_en),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .busy(busy), .rd_done(rd_done),
    .wr_done(wr_done), .err(err)
  );

  div_mem_seq #(
    .NUM_DIV(1), .NUM_LINES(2), .WR_GAP(0)
  ) u_dut2 (
    .clk(clk), .reset(reset), .start(start2),
    .div_done(dd2),
    .rd_addr1(rd_addr1_2), .rd_addr2(rd_addr2_2),
    .rd_data_rdy(rd_data_rdy_2), .div_en(div_en_2),
    .wr_en(wr_en_2), .wr_addr(wr_addr_2),
    .busy(busy_2), .rd_done(rd_done_2),
    .wr_done(wr_done_2), .err(err_2)
  );

  int nchk = 0;
  int nerr = 0;
  int cyc = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cycle %0d: got %0d want %0d",
               nm, cyc, act, exp);
    end
  endtask

  // Run model: schedules the edge after which each strobe must show.
  bit          m_run = 0;
  bit          m_wait = 0;
  bit          m_acc = 0;
  int          mk = 0;
  int          t_st = -1, t_addr = -1, t_den = -1, t_e = -1;
  int          t_wa = -1, t_wb = -1, t_done = -1;
  logic [15:0] e_a1 = 0, e_a2 = 0, e_wa = 0;
  logic        e_den = 0, e_wen = 0, e_busy = 0;
  logic        e_done = 0, e_err = 0;

  always @(posedge clk) begin
    cyc++;
    m_acc = 0;
    e_den = 0;
    e_wen = 0;
    e_done = 0;
    if (reset) begin
      m_run = 0; m_wait = 0; mk = 0;
      e_a1 = 0; e_a2 = 0; e_wa = 0;
      e_busy = 0; e_err = 0;
      t_st = -1; t_addr = -1; t_den = -1; t_e = -1;
      t_wa = -1; t_wb = -1; t_done = -1;
    end else begin
      e_busy = m_run && (cyc > t_st);
      if (!m_run && start) begin
        m_run = 1; m_acc = 1; mk = 0;
        e_err = 0; t_st = cyc; t_addr = cyc + 1;
      end
      if (cyc == t_addr) begin
        e_a1 = 16'(RB + 2 * mk);
        e_a2 = 16'(RB + 2 * mk + 1);
        t_den = cyc + 1 + RL;
      end
      if (cyc == t_den) begin
        e_den = 1; t_e = cyc; m_wait = 1;
      end else if (m_wait && cyc - t_e >= 2 && &dd) begin
        m_wait = 0; t_wa = cyc + 1;
      end else if (m_wait && cyc - t_e == TO) begin
        m_wait = 0; e_err = 1; t_done = cyc + 1;
      end
      if (cyc == t_wa) begin
        e_wen = 1; e_wa = 16'(WB + 2 * mk);
        t_wb = cyc + WG + 1;
      end
      if (cyc == t_wb) begin
        e_wen = 1; e_wa = 16'(WB + 2 * mk + 1);
        if (mk < NL / 2 - 1) begin
          mk++; t_addr = cyc + WG + 1;
        end else begin
          t_done = cyc + WG + 1;
        end
      end
      if (cyc == t_done) begin
        e_done = 1; m_run = 0;
      end
    end
  end

  int den_n = 0, wr_n = 0, done_n = 0;

  always @(negedge clk) begin
    chk("rd_addr1", rd_addr1, e_a1);
    chk("rd_addr2", rd_addr2, e_a2);
    chk("rd_data_rdy", rd_data_rdy, e_den);
    chk("div_en", div_en, e_den);
    chk("wr_en", wr_en, e_wen);
    chk("wr_addr", wr_addr, e_wa);
    chk("busy", busy, e_busy);
    chk("rd_done", rd_done, e_done);
    chk("wr_done", wr_done, e_done);
    chk("err", err, e_err);
    if (m_acc) begin
      den_n = 0; wr_n = 0; done_n = 0;
    end
    if (div_en) begin
      chk("rd_seq", rd_addr1, 32'(RB + 2 * den_n));
      den_n++;
    end
    if (wr_en) begin
      chk("wr_seq", wr_addr, 32'(WB + wr_n));
      wr_n++;
    end
    if (rd_done) done_n++;
  end

  // Divider stand-in: 0 = done 3 cycles after launch,
  // 1 = always done, 2 = divider 3 never finishes.
  int mode = 1;
  int dly = 0;
  always @(negedge clk) begin
    if (mode == 0) begin
      if (div_en) begin
        dd = 8'h00; dly = 3;
      end else if (dly > 0) begin
        dly--;
        if (dly == 0) dd = 8'hFF;
      end
    end else if (mode == 1) begin
      dd = 8'hFF;
    end else begin
      dd = 8'hF7;
    end
  end

  task automatic go(output int t);
    @(negedge clk); #1;
    start = 1;
    @(negedge clk); #1;
    start = 0;
    t = cyc;
  endtask

  task automatic wait_done(input int budget, output int de);
    de = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (rd_done) begin
        de = cyc;
        break;
      end
    end
    if (de < 0) begin
      nchk++; nerr++;
      $display("FAIL wait_done: no done within %0d", budget);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int t, de, n, rel;
  bit found;

  initial begin
    reset = 1; start = 0; start2 = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_addr1", rd_addr1, 0);
    chk("rst_waddr", wr_addr, 0);
    chk("rst_err", err, 0);
    chk("rst_busy2", busy_2, 0);
    reset = 0;

    // full run, dividers finish 3 cycles after launch
    mode = 0;
    go(t);
    @(negedge clk); #1;
    chk("lat_addr1", rd_addr1, 64);
    chk("lat_addr2", rd_addr2, 65);
    chk("lat_en_e1", div_en, 0);
    repeat (2) begin
      @(negedge clk); #1;
      chk("lat_en_early", div_en, 0);
    end
    @(negedge clk); #1;
    chk("lat_en_e4", div_en, 1);
    chk("lat_edge", cyc - t, 4);
    wait_done(3000, de);
    @(negedge clk); #1;
    chk("a_den_cnt", den_n, 32);
    chk("a_wr_cnt", wr_n, 64);
    chk("a_done_cnt", done_n, 1);
    chk("a_busy_end", busy, 0);

    // dividers always done: blanking sets pair period to 12
    mode = 1;
    go(t);
    wait_done(3000, de);
    chk("b_len", de - t, 385);
    @(negedge clk); #1;
    chk("b_den_cnt", den_n, 32);
    chk("b_wr_cnt", wr_n, 64);

    // one divider stuck: timeout on pair 0
    mode = 2;
    go(t);
    wait_done(1500, de);
    chk("c_len", de - t, 1028);
    chk("c_err", err, 1);
    @(negedge clk); #1;
    chk("c_wr_cnt", wr_n, 0);
    chk("c_den_cnt", den_n, 1);
    chk("c_busy", busy, 0);
    chk("c_err_hold", err, 1);

    // restart clears err; stray start; reset inside pair 5
    mode = 1;
    go(t);
    chk("d_err_clr", err, 0);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk); #1;
      if (div_en && rd_addr1 == 16'd68) found = 1;
    end
    chk("d_pair2_seen", found, 1);
    @(negedge clk); #1;
    start = 1;
    @(negedge clk); #1;
    start = 0;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk); #1;
      if (wr_en && wr_addr == 16'd138) found = 1;
    end
    chk("d_pair5_wra", found, 1);
    reset = 1;
    @(negedge clk); #1;
    chk("d_rst_busy", busy, 0);
    chk("d_rst_wen", wr_en, 0);
    chk("d_rst_waddr", wr_addr, 0);
    chk("d_rst_addr1", rd_addr1, 0);
    reset = 0;
    n = 0;
    repeat (20) begin
      @(negedge clk); #1;
      if (wr_en || div_en || busy) n++;
    end
    chk("d_quiet", n, 0);
    chk("d_wr_cnt", wr_n, 11);
    chk("d_den_cnt", den_n, 6);

    // two lines, no write gap, one divider
    @(negedge clk); #1;
    start2 = 1;
    @(negedge clk); #1;
    start2 = 0;
    t = cyc;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk); #1;
      rel = cyc - t;
      chk("e_den", div_en_2, (rel == 4) ? 1 : 0);
      chk("e_wen", wr_en_2,
          (rel == 7 || rel == 8) ? 1 : 0);
      chk("e_done", wr_done_2, (rel == 9) ? 1 : 0);
      chk("e_busy", busy_2,
          (rel >= 1 && rel <= 9) ? 1 : 0);
      if (rel == 1) chk("e_addr2", rd_addr2_2, 65);
      if (rel == 7) chk("e_wa0", wr_addr_2, 128);
      if (rel == 8) chk("e_wa1", wr_addr_2, 129);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
